uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the existing TX block.
- Consumes the same 16x-oversampled baud_rate tick produced by BaudRateGenerator.
- Recovers 8N1 frames from the serial line, presents the byte on d_out and pulses rx_done for one clk cycle per frame.
- Sits between the external rx pin and the interface/FIFO logic that consumes received bytes.

Parameters:
- DBIT, 8: data bits per frame, LSB first.
- SB_TICK, 16: baud ticks spent in the stop bit (16 = 1 stop bit, 32 = 2).
- OVERSAMPLE, 16: baud ticks per bit; the mid-bit sample point is OVERSAMPLE/2-1.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- baud_rate  in  1  oversample tick, one clk cycle wide, OVERSAMPLE per bit period.
- rx  in  1  serial input; idles high.
- d_out  out  DBIT  last received byte; held until the next completed frame.
- rx_done  out  1  one-clk pulse when d_out is updated.
- frame_err  out  1  stop-bit status of the last frame; valid from rx_done on.

Behaviour:
- Reset (async assert, sync release): state=IDLE, counters 0, shift register 0, d_out=0, rx_done=0, frame_err=0.
- rx passes through a 2-flop synchronizer reset to 1; all decisions use the synchronized value rxs. Sync latency is 2 clk.
- Tick counter s (log2 of max(OVERSAMPLE,SB_TICK) bits) and bit counter n advance only on cycles where baud_rate=1.
- IDLE: rxs=0 -> START, s=0. The falling-edge check is made every clk, not only on ticks.
- START: on each tick, if s==OVERSAMPLE/2-1:
  - rxs=0 -> DATA, s=0, n=0.
  - rxs=1 -> IDLE, glitch rejected, no outputs change.
  - Otherwise s++.
- DATA: on each tick, if s==OVERSAMPLE-1:
  - shift b={rxs,b[DBIT-1:1]} (LSB first), s=0.
  - n==DBIT-1 -> STOP, else n++.
  - Otherwise s++.
- STOP: on each tick, if s==SB_TICK-1:
  - d_out<=b, frame_err<=~rxs, rx_done=1 for exactly this clk cycle.
  - -> IDLE.
  - Otherwise s++.
- Latency: rx_done asserts at the tick nearest mid-stop-bit, about 9.5 bit periods after the start edge, plus 2 clk sync.
- frame_err=1 does not suppress rx_done or the d_out update.
- Line held low (break): after the errored frame, IDLE immediately re-enters START; that frame also reports frame_err. No lockup.
- Back-to-back frames: a start edge arriving in the half bit after mid-stop is accepted with no lost frame.
- baud_rate high every clk is legal; the FSM simply runs at clk rate.
- rst_n asserted mid-frame: immediate return to IDLE with all outputs 0. The partial frame is discarded and no rx_done is produced.
- rx_done is never asserted in two consecutive cycles.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - adds state PARITY between DATA and STOP, lasting OVERSAMPLE ticks, sampled mid-bit.
  - expects even parity (XOR of data bits and parity bit = 0).
  - adds port parity_err out 1, reset 0, updated together with d_out at rx_done.
- Undefined: no PARITY state and no parity_err port; frame is start+DBIT+stop.

Test Plan:
- Reset, then send 0x99 (line 0,1,0,0,1,1,0,0,1,1) at 16 ticks/bit -> exactly one rx_done pulse, d_out=0x99, frame_err=0.
- Send 0x99 then 0xDA with zero idle gap -> two rx_done pulses about 160 ticks apart, d_out=0x99 then 0xDA, no frame_err.
- Drive rx low for 4 ticks then high -> no rx_done, FSM back in IDLE, d_out unchanged; a following 0x55 frame is received correctly.
- Send 0xA5 with stop bit 0, then line high -> rx_done pulses, d_out=0xA5, frame_err=1; the next valid 0x3C frame clears frame_err to 0.
- Assert rst_n=0 during data bit 4 of 0xFF -> d_out=0 and rx_done=0 immediately, no pulse for that frame; after release, 0x81 is received correctly.
- With UART_RX_PARITY_EN: 0x99 with parity bit 0 -> parity_err=0; 0x99 with parity bit 1 -> parity_err=1, d_out=0x99, rx_done pulses in both cases.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x-oversampled baud tick; recovers frames from rx,
// presents the byte on d_out and pulses rx_done. Define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            baud_rate,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            rx_meta_q, rxs_q;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    // Synchronizer resets to the idle-high line level so reset release never looks like a start edge.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // NOTE: the shift register is a handful of flops, not a memory, so it is reset along with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif

        case (state_q)
            // Start-edge detection runs every clk so the start bit is found within one cycle.
            ST_IDLE: begin
                if (!rxs_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end

            ST_START: begin
                if (baud_rate) begin
                    if (s_q == S_MID) begin
                        if (!rxs_q) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            ST_DATA: begin
                if (baud_rate) begin
                    if (s_q == S_BIT) begin
                        b_d = {rxs_q, b_q[DBIT-1:1]};
                        s_d = '0;
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_rate) begin
                    if (s_q == S_BIT) begin
                        par_d   = rxs_q;
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`endif

            // Stop is sampled SB_TICK ticks after the last mid-bit sample, i.e. mid-stop for one stop bit.
            ST_STOP: begin
                if (baud_rate) begin
                    if (s_q == S_STOP) begin
                        dout_d  = b_q;
                        ferr_d  = ~rxs_q;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^b_q) ^ par_q;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign d_out     = dout_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

`ifndef SYNTHESIS
    // A frame is always several ticks long, so two adjacent done pulses indicate a broken FSM.
    rx_done_single_cycle: assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames are driven on rx, expected bytes queued,
// and every rx_done pulse pops and compares one entry.
module tb_uart_rx;

    localparam int DBIT = 8;
    localparam int OS   = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_rate = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    exp_t   sb[$];
    longint done_times[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     div = 4;
    logic   prev_done = 1'b0;

    uart_rx #(.DBIT(DBIT), .SB_TICK(16), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_rate (baud_rate),
        .rx        (rx),
        .d_out     (d_out),
        .rx_done   (rx_done),
        .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One baud tick every div clocks, driven on the falling edge.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (cnt >= div - 1) begin
                baud_rate = 1'b1;
                cnt = 0;
            end else begin
                baud_rate = 1'b0;
                cnt++;
            end
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (OS * div) @(negedge clk);
    endtask

    // A zero stop bit is held low just past mid-bit, then the line returns high.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        exp_t e;
        e.data = data;
        e.ferr = ~stop;
        e.perr = (^data) ^ par;
        sb.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < DBIT; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        if (stop) begin
            send_bit(1'b1);
        end else begin
            rx = 1'b0;
            repeat ((OS / 2 + 2) * div) @(negedge clk);
            rx = 1'b1;
            repeat ((OS / 2 - 2) * div) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 2 * FRAME_BITS * OS * div) begin
            @(negedge clk);
            k++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic idle_bits(input int nbits);
        rx = 1'b1;
        repeat (nbits * OS * div) @(negedge clk);
    endtask

    // Monitor: every rx_done pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_done) begin
                check("rx_done_width", prev_done, 1'b0);
                done_times.push_back(cyc);
                if (sb.size() == 0) begin
                    check("spurious_rx_done", rx_done, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("d_out", d_out, e.data);
                    check("frame_err", frame_err, e.ferr);
`ifdef UART_RX_PARITY_EN
                    check("parity_err", parity_err, e.perr);
`endif
                end
            end
            prev_done = rx_done;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, %0d queued frames", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_d_out", d_out, 0);
        check("reset_rx_done", rx_done, 0);
        check("reset_frame_err", frame_err, 0);
`ifdef UART_RX_PARITY_EN
        check("reset_parity_err", parity_err, 0);
`endif
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame
        done_times.delete();
        send_frame(8'h99, 1'b1, 1'b0);
        wait_drain("t1_drain");
        check("t1_pulses", done_times.size(), 1);
        idle_bits(1);
        check("t1_d_out_held", d_out, 8'h99);

        // Back-to-back frames, zero idle gap
        done_times.delete();
        send_frame(8'h99, 1'b1, 1'b0);
        send_frame(8'hDA, 1'b1, 1'b0);
        wait_drain("t2_drain");
        check("t2_pulses", done_times.size(), 2);
        if (done_times.size() == 2)
            check("t2_spacing", 32'(done_times[1] - done_times[0]), FRAME_BITS * OS * div);
        idle_bits(1);

        // Start glitch shorter than half a bit
        done_times.delete();
        rx = 1'b0;
        repeat (4 * div) @(negedge clk);
        idle_bits(3);
        check("t3_glitch_pulses", done_times.size(), 0);
        check("t3_d_out_held", d_out, 8'hDA);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_drain("t3_drain");
        idle_bits(1);

        // Framing error, then recovery
        send_frame(8'hA5, 1'b0, 1'b0);
        wait_drain("t4_drain_err");
        idle_bits(2);
        check("t4_frame_err_held", frame_err, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_drain("t4_drain_ok");
        check("t4_frame_err_clear", frame_err, 1'b0);
        idle_bits(1);

        // Reset during data bit 4 of 0xFF
        done_times.delete();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (OS * div / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_d_out", d_out, 0);
        check("t5_rst_rx_done", rx_done, 0);
        check("t5_rst_frame_err", frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_bits(5);
        check("t5_no_pulse", done_times.size(), 0);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_drain("t5_drain");
        idle_bits(1);

        // Baud tick asserted every clk
        div = 1;
        repeat (4) @(negedge clk);
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_drain("t6_drain");
        idle_bits(1);
        div = 4;
        repeat (8) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h99, 1'b1, 1'b0);
        wait_drain("t7_drain_good");
        idle_bits(1);
        send_frame(8'h99, 1'b1, 1'b1);
        wait_drain("t7_drain_bad");
        idle_bits(1);
`endif

        check("final_queue_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
